// File: rtl/mem_access_ctrl_if.sv
// Bundle of the signals exchanged by the data-memory access controller.
// Covers the pipeline request/response handshake and the DATA_MEM bus.
//
//   req_valid/req_ready     pipeline request handshake (ready = controller idle)
//   req_we/req_byte/req_signed, req_addr, req_wdata   request attributes
//   rsp_valid/rsp_rdata     one-cycle completion pulse and load result
//   mem_w/mem_r/mem_byte_en, mem_addr, mem_wdata      DATA_MEM inputs
//   mem_rdata               DATA_MEM DATA_out
//
// Modports:
//   master  the controller; it drives the memory bus and the response.
//   slave   the environment (pipeline + memory) facing the controller.
interface mem_access_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic          req_byte;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          mem_w;
  logic          mem_r;
  logic          mem_byte_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_byte, req_signed, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_w, mem_r, mem_byte_en, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_byte, req_signed, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_w, mem_r, mem_byte_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the MEM stage.
// Converts pipeline load/store requests into DATA_MEM transactions, handling
// word and byte accesses, byte-load sign/zero extension, a configurable read
// latency, and splitting of odd-address word accesses into two byte accesses
// (little-endian: low byte at the odd address, high byte at address+1).
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   mem_access_ctrl_if.master: request handshake, response, DATA_MEM bus
//
// Parameters:
//   AW      byte address width
//   DW      data width (a word is two bytes)
//   RD_LAT  cycles from the mem_r cycle to the cycle mem_rdata is sampled (0..3)
module mem_access_ctrl #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_ctrl_if.master  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACC    = 3'd1;
  localparam logic [2:0] S_RWAIT  = 3'd2;
  localparam logic [2:0] S_LO     = 3'd3;
  localparam logic [2:0] S_LOWAIT = 3'd4;
  localparam logic [2:0] S_HI     = 3'd5;
  localparam logic [2:0] S_HIWAIT = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [1:0] LAT = 2'(RD_LAT);

  logic [2:0]    state;
  logic [1:0]    cnt;
  logic          r_we;
  logic          r_byte;
  logic          r_signed;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [7:0]    lo_byte;
  logic [AW-1:0] addr_hi;

  // Second half of a split access; wraps naturally at the top of the space.
  assign addr_hi = r_addr + {{(AW-1){1'b0}}, 1'b1};

  assign bus.req_ready = (state == S_IDLE);

  // Place a single byte on lane [7:0], upper lane zero.
  function automatic logic [DW-1:0] lane0(input logic [7:0] b);
    return {{(DW-8){1'b0}}, b};
  endfunction

  // Byte-load extension: sign-extend only when the request asked for it.
  function automatic logic [DW-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    return {{(DW-8){b[7] & sgn}}, b};
  endfunction

  // Result of a single (aligned) read: full word, or extended low byte.
  function automatic logic [DW-1:0] load_result(input logic [DW-1:0] d,
                                                input logic byt, input logic sgn);
    return byt ? ext_byte(d[7:0], sgn) : d;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= 2'd0;
      r_we            <= 1'b0;
      r_byte          <= 1'b0;
      r_signed        <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      lo_byte         <= 8'd0;
      bus.mem_w       <= 1'b0;
      bus.mem_r       <= 1'b0;
      bus.mem_byte_en <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
    end else begin
      // Strobes and the response pulse last exactly one cycle unless a
      // branch below issues the next one; address/data hold their values.
      bus.mem_w       <= 1'b0;
      bus.mem_r       <= 1'b0;
      bus.mem_byte_en <= 1'b0;
      bus.rsp_valid   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_we            <= bus.req_we;
            r_byte          <= bus.req_byte;
            r_signed        <= bus.req_signed;
            r_addr          <= bus.req_addr;
            r_wdata         <= bus.req_wdata;
            bus.mem_w       <= bus.req_we;
            bus.mem_r       <= ~bus.req_we;
            bus.mem_addr    <= bus.req_addr;
            if (bus.req_byte || !bus.req_addr[0]) begin
              state           <= S_ACC;
              bus.mem_byte_en <= bus.req_byte;
              bus.mem_wdata   <= bus.req_byte ? lane0(bus.req_wdata[7:0]) : bus.req_wdata;
            end else begin
              // Odd-address word: first the low byte at the given address.
              state           <= S_LO;
              bus.mem_byte_en <= 1'b1;
              bus.mem_wdata   <= lane0(bus.req_wdata[7:0]);
            end
          end
        end

        S_ACC: begin
          if (r_we) begin
            state         <= S_DONE;
            bus.rsp_valid <= 1'b1;
          end else if (RD_LAT == 0) begin
            state         <= S_DONE;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= load_result(bus.mem_rdata, r_byte, r_signed);
          end else begin
            state <= S_RWAIT;
            cnt   <= 2'd1;
          end
        end

        S_RWAIT: begin
          if (cnt == LAT) begin
            state         <= S_DONE;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= load_result(bus.mem_rdata, r_byte, r_signed);
          end else begin
            cnt <= cnt + 2'd1;
          end
        end

        S_LO: begin
          if (r_we || RD_LAT == 0) begin
            if (!r_we) lo_byte <= bus.mem_rdata[7:0];
            state           <= S_HI;
            bus.mem_w       <= r_we;
            bus.mem_r       <= ~r_we;
            bus.mem_byte_en <= 1'b1;
            bus.mem_addr    <= addr_hi;
            bus.mem_wdata   <= lane0(r_wdata[15:8]);
          end else begin
            state <= S_LOWAIT;
            cnt   <= 2'd1;
          end
        end

        S_LOWAIT: begin
          if (cnt == LAT) begin
            lo_byte         <= bus.mem_rdata[7:0];
            state           <= S_HI;
            bus.mem_r       <= 1'b1;
            bus.mem_byte_en <= 1'b1;
            bus.mem_addr    <= addr_hi;
            bus.mem_wdata   <= lane0(r_wdata[15:8]);
          end else begin
            cnt <= cnt + 2'd1;
          end
        end

        S_HI: begin
          if (r_we) begin
            state         <= S_DONE;
            bus.rsp_valid <= 1'b1;
          end else if (RD_LAT == 0) begin
            state         <= S_DONE;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= {bus.mem_rdata[7:0], lo_byte};
          end else begin
            state <= S_HIWAIT;
            cnt   <= 2'd1;
          end
        end

        S_HIWAIT: begin
          if (cnt == LAT) begin
            state         <= S_DONE;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= {bus.mem_rdata[7:0], lo_byte};
          end else begin
            cnt <= cnt + 2'd1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the data-memory port. Lives in the MEM stage and turns pipeline load/store requests into DATA_MEM transactions (MEM_W, MEM_R, BYTE_EN, ADDR, DATA_in, DATA_out).
- Handles word and byte accesses, byte-load sign/zero extension, and the read latency of the memory.
- Splits misaligned word accesses into two byte transactions.
- Holds the pipeline through a ready/valid handshake while busy.

Parameters:
- AW, 16, address width (byte address).
- DW, 16, data width (word = 2 bytes).
- RD_LAT, 1, cycles from the mem_r issue cycle to the cycle mem_rdata is sampled. Legal range 0..3; 0 means sample in the issue cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  pipeline request present.
- req_ready  out  1  controller can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_signed  in  1  byte load: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  AW  byte address.
- req_wdata  in  DW  store data; byte store uses [7:0].
- rsp_valid  out  1  one-cycle pulse: access complete.
- rsp_rdata  out  DW  load result, valid with rsp_valid; holds its value afterwards.
- mem_w  out  1  to DATA_MEM MEM_W.
- mem_r  out  1  to DATA_MEM MEM_R.
- mem_byte_en  out  1  to DATA_MEM BYTE_EN.
- mem_addr  out  AW  to DATA_MEM ADDR.
- mem_wdata  out  DW  to DATA_MEM DATA_in.
- mem_rdata  in  DW  from DATA_MEM DATA_out.

Behaviour:
- Memory convention, little-endian:
  - Word at even address A: low byte at A, high byte at A+1.
  - Byte write stores mem_wdata[7:0] at mem_addr.
  - Byte read returns the byte in mem_rdata[7:0]; bits [15:8] are ignored.
- Reset: state=IDLE; mem_w, mem_r, mem_byte_en = 0; mem_addr, mem_wdata, rsp_rdata = 0; rsp_valid = 0; req_ready = 1.
- Outputs are registered except req_ready, which is (state==IDLE).
- FSM states: IDLE, ACC, RWAIT, LO, LOWAIT, HI, HIWAIT, DONE.
  - IDLE: on req_valid, latch the request.
    - Byte access, or word access with addr[0]=0 -> ACC.
    - Word access with addr[0]=1 -> LO.
  - ACC: one cycle, drive the access.
    - Store -> DONE.
    - Load -> RWAIT for RD_LAT cycles, sample mem_rdata, then -> DONE.
  - LO: byte access at addr. Store drives wdata[7:0]. Load samples byte after RD_LAT cycles in LOWAIT -> HI.
  - HI: byte access at addr+1, wrapping modulo 2^AW (0xFFFF+1 = 0x0000). Store drives wdata[15:8] on lane [7:0]. Load samples after RD_LAT in HIWAIT -> DONE.
  - DONE: rsp_valid=1 for one cycle -> IDLE. No new request is accepted in DONE.
- Strobes: mem_w and mem_r are high exactly one cycle per transaction. Between transactions mem_w, mem_r and mem_byte_en are 0; mem_addr and mem_wdata hold their last values.
- Load result:
  - Word: mem_rdata.
  - Byte: {8{b[7]&req_signed}, b}.
  - Misaligned word: {hi_byte, lo_byte}.
- Store responses: rsp_valid pulses; rsp_rdata is unchanged.
- Latency, with the request accepted at cycle 0:
  - Aligned store: mem_w at cycle 1, rsp_valid at cycle 2.
  - Aligned load: mem_r at cycle 1, rsp_valid at cycle 2+RD_LAT.
  - Misaligned store: writes at cycles 1 and 2, rsp_valid at cycle 3.
  - Misaligned load: rsp_valid at cycle 3+2*RD_LAT.
- Back-to-back: a new request is accepted the cycle after DONE (in IDLE). req_valid while busy is ignored; the pipeline must hold it.
- Reset mid-operation returns to IDLE immediately with all strobes low. The first byte of an interrupted misaligned store may already be written; this is accepted behaviour.

Test Plan:
- Aligned word store/load: store 0x1234 @0x0002, then load @0x0002, RD_LAT=1 -> mem_w pulse at cycle 1, rsp_valid at cycle 2; load rsp_valid at cycle 3 with rsp_rdata=0x1234.
- Byte store and extension: byte store 0xAA @0x0005, then signed byte load @0x0005 -> 0xFFAA; unsigned byte load -> 0x00AA; mem_byte_en=1 on all three accesses.
- Misaligned word: store 0xBEEF @0x0007 -> byte writes 0xEF@0x0007, then 0xBE@0x0008, rsp at cycle 3. Load @0x0007 -> 0xBEEF at cycle 5.
- Address wrap: misaligned load @0xFFFF -> second access mem_addr=0x0000; result {mem[0x0000], mem[0xFFFF]}.
- Handshake: req_valid held high through a load -> req_ready=0 from cycle 1 until DONE; the second request is accepted in the cycle after DONE; exactly one rsp_valid per request.
- Reset mid-op: assert rst during LOWAIT -> mem_r=0, rsp_valid=0, req_ready=1 immediately. A subsequent aligned load completes normally.
